// File: rtl/issue_warp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : issue_warp_sched_pkg
// Brief    : Shared constants and width helpers for the warp issue scheduler.
// Revision : 1.0
// ============================================================================
package issue_warp_sched_pkg;

    localparam int ARB_RR     = 0;
    localparam int ARB_GREEDY = 1;

    // Index width for a power-of-2 count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed width of one buffered instruction entry {wb, rd, rs1, rs2, rs3, payload}.
    function automatic int ent_bits(input int nr_w, input int payload_w);
        return 1 + 4 * nr_w + payload_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_warp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : issue_warp_fifo
// Brief    : Single-warp circular instruction buffer with wrapping pointers.
// Revision : 1.0
// ============================================================================
module issue_warp_fifo
    import issue_warp_sched_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = idx_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/issue_warp_sched.sv
`default_nettype none
// ============================================================================
// Module   : issue_warp_sched
// Brief    : Per-warp instruction buffers, register scoreboard and warp arbiter
//            feeding a registered issue stage.
// Revision : 1.0
// ============================================================================
module issue_warp_sched
    import issue_warp_sched_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int IBUF_DEPTH = 2,
    parameter int NUM_REGS   = 64,
    parameter int PAYLOAD_W  = 64,
    parameter int ARB_MODE   = ARB_RR,
    localparam int NW_W      = idx_w(NUM_WARPS),
    localparam int NR_W      = idx_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [NW_W-1:0]      dec_wid,
    input  logic                 dec_wb,
    input  logic [NR_W-1:0]      dec_rd,
    input  logic [NR_W-1:0]      dec_rs1,
    input  logic [NR_W-1:0]      dec_rs2,
    input  logic [NR_W-1:0]      dec_rs3,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    input  logic                 wb_valid,
    input  logic [NW_W-1:0]      wb_wid,
    input  logic [NR_W-1:0]      wb_rd,
    input  logic                 wb_eop,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [NW_W-1:0]      iss_wid,
    output logic                 iss_wb,
    output logic [NR_W-1:0]      iss_rd,
    output logic [NR_W-1:0]      iss_rs1,
    output logic [NR_W-1:0]      iss_rs2,
    output logic [NR_W-1:0]      iss_rs3,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic [31:0]          perf_stalls
);

    typedef struct packed {
        logic                 wb;
        logic [NR_W-1:0]      rd;
        logic [NR_W-1:0]      rs1;
        logic [NR_W-1:0]      rs2;
        logic [NR_W-1:0]      rs3;
        logic [PAYLOAD_W-1:0] payload;
    } issue_sched_ent_t;

    localparam int ENT_W = ent_bits(NR_W, PAYLOAD_W);

    issue_sched_ent_t     w_dec_ent;
    issue_sched_ent_t     w_head [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_full, w_empty, w_push, w_pop, w_elig;
    logic [NW_W-1:0]      w_sel;
    logic                 w_can_load, w_fire;

    logic [NUM_REGS-1:0]  r_sb [NUM_WARPS];
    logic [NW_W-1:0]      r_rr, r_last;
    logic                 r_iss_valid;
    logic [NW_W-1:0]      r_iss_wid;
    issue_sched_ent_t     r_iss_ent;
    logic [31:0]          r_stalls;

    assign w_dec_ent = '{wb: dec_wb, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                         rs3: dec_rs3, payload: dec_payload};
    assign dec_ready = !w_full[dec_wid];

    generate
        for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
            issue_warp_fifo #(
                .DEPTH  (IBUF_DEPTH),
                .DATA_W (ENT_W)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .i_push  (w_push[g]),
                .i_data  (w_dec_ent),
                .i_pop   (w_pop[g]),
                .o_data  (w_head[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g])
            );

            assign w_push[g] = dec_valid && dec_ready && (dec_wid == NW_W'(g));
            assign w_pop[g]  = w_fire && (w_sel == NW_W'(g));
            // Register 0 is hardwired clear, so it never blocks.
            assign w_elig[g] = !w_empty[g]
                && !(r_sb[g][w_head[g].rs1] && (w_head[g].rs1 != '0))
                && !(r_sb[g][w_head[g].rs2] && (w_head[g].rs2 != '0))
                && !(r_sb[g][w_head[g].rs3] && (w_head[g].rs3 != '0))
                && !(w_head[g].wb && r_sb[g][w_head[g].rd] && (w_head[g].rd != '0));
        end
    endgenerate

    assign w_can_load = !r_iss_valid || iss_ready;
    assign w_fire     = w_can_load && (|w_elig);

    always_comb begin
        logic            found;
        logic [NW_W-1:0] idx;
        w_sel = r_rr;
        found = 1'b0;
        idx   = r_rr;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = r_rr + NW_W'(i);
            if (!found && w_elig[idx]) begin
                w_sel = idx;
                found = 1'b1;
            end
        end
        if ((ARB_MODE == ARB_GREEDY) && w_elig[r_last]) begin
            w_sel = r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_valid <= 1'b0;
            r_iss_wid   <= '0;
            r_iss_ent   <= '0;
            r_rr        <= '0;
            r_last      <= '0;
            r_stalls    <= '0;
            for (int w = 0; w < NUM_WARPS; w++) r_sb[w] <= '0;
        end else begin
            if (wb_valid && wb_eop) r_sb[wb_wid][wb_rd] <= 1'b0;
            // The issue-side set follows the clear so that a collision leaves the bit set.
            if (w_fire) begin
                r_iss_valid <= 1'b1;
                r_iss_wid   <= w_sel;
                r_iss_ent   <= w_head[w_sel];
                r_rr        <= w_sel + 1'b1;
                r_last      <= w_sel;
                if (w_head[w_sel].wb && (w_head[w_sel].rd != '0))
                    r_sb[w_sel][w_head[w_sel].rd] <= 1'b1;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end
            if (w_can_load && !(&w_empty) && !(|w_elig) && (r_stalls != '1))
                r_stalls <= r_stalls + 32'd1;
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_wid     = r_iss_wid;
    assign iss_wb      = r_iss_ent.wb;
    assign iss_rd      = r_iss_ent.rd;
    assign iss_rs1     = r_iss_ent.rs1;
    assign iss_rs2     = r_iss_ent.rs2;
    assign iss_rs3     = r_iss_ent.rs3;
    assign iss_payload = r_iss_ent.payload;
    assign perf_stalls = r_stalls;

endmodule
`default_nettype wire

// File: tb/tb_issue_warp_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_warp_sched
// Brief    : Directed plus random checks of a round-robin and a greedy instance
//            against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_issue_warp_sched;

    localparam int NW    = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        wb;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rs3;
        logic [63:0] pl;
    } m_ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_wb, wb_valid, wb_eop, iss_ready;
    logic [1:0]  dec_wid, wb_wid;
    logic [5:0]  dec_rd, dec_rs1, dec_rs2, dec_rs3, wb_rd;
    logic [63:0] dec_payload;

    logic        dec_ready_o [2];
    logic        iss_valid_o [2];
    logic [1:0]  iss_wid_o   [2];
    logic        iss_wb_o    [2];
    logic [5:0]  iss_rd_o    [2];
    logic [5:0]  iss_rs1_o   [2];
    logic [5:0]  iss_rs2_o   [2];
    logic [5:0]  iss_rs3_o   [2];
    logic [63:0] iss_pl_o    [2];
    logic [31:0] stalls_o    [2];

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference model state per instance (0 = round-robin, 1 = greedy)
    m_ent_t  m_q    [2][NW][$];
    bit      m_sb   [2][NW][64];
    int      m_rr   [2];
    int      m_last [2];
    bit      m_val  [2];
    int      m_wid  [2];
    m_ent_t  m_out  [2];
    longint  m_stall[2];

    logic [63:0] rec_pl  [2][$];
    int          rec_wid [2][$];

    initial forever #5 clk = ~clk;

    issue_warp_sched #(.NUM_WARPS(4), .IBUF_DEPTH(2), .NUM_REGS(64), .PAYLOAD_W(64), .ARB_MODE(0)) dut_rr (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready_o[0]), .dec_wid(dec_wid), .dec_wb(dec_wb),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .dec_payload(dec_payload),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .iss_valid(iss_valid_o[0]), .iss_ready(iss_ready), .iss_wid(iss_wid_o[0]), .iss_wb(iss_wb_o[0]),
        .iss_rd(iss_rd_o[0]), .iss_rs1(iss_rs1_o[0]), .iss_rs2(iss_rs2_o[0]), .iss_rs3(iss_rs3_o[0]),
        .iss_payload(iss_pl_o[0]), .perf_stalls(stalls_o[0])
    );

    issue_warp_sched #(.NUM_WARPS(4), .IBUF_DEPTH(2), .NUM_REGS(64), .PAYLOAD_W(64), .ARB_MODE(1)) dut_gr (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready_o[1]), .dec_wid(dec_wid), .dec_wb(dec_wb),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .dec_payload(dec_payload),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .iss_valid(iss_valid_o[1]), .iss_ready(iss_ready), .iss_wid(iss_wid_o[1]), .iss_wb(iss_wb_o[1]),
        .iss_rd(iss_rd_o[1]), .iss_rs1(iss_rs1_o[1]), .iss_rs2(iss_rs2_o[1]), .iss_rs3(iss_rs3_o[1]),
        .iss_payload(iss_pl_o[1]), .perf_stalls(stalls_o[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit busy(input int k, input int w, input logic [5:0] r);
        return (r != 6'd0) && m_sb[k][w][r];
    endfunction

    function automatic bit ready_ok(input m_ent_t e, input int k, input int w);
        return !busy(k, w, e.rs1) && !busy(k, w, e.rs2) && !busy(k, w, e.rs3)
            && !(e.wb && busy(k, w, e.rd));
    endfunction

    // One clock of architectural behaviour, computed from the values present at the edge.
    task automatic model_step(input int k);
        bit accept, can_load, any_ne;
        bit el [NW];
        int win;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                m_q[k][w].delete();
                for (int r = 0; r < 64; r++) m_sb[k][w][r] = 1'b0;
            end
            m_rr[k] = 0; m_last[k] = 0; m_val[k] = 1'b0; m_stall[k] = 0;
            return;
        end
        accept   = dec_valid && (m_q[k][dec_wid].size() < DEPTH);
        can_load = !m_val[k] || iss_ready;
        any_ne   = 1'b0;
        win      = -1;
        for (int w = 0; w < NW; w++) begin
            el[w]  = (m_q[k][w].size() > 0) && ready_ok(m_q[k][w][0], k, w);
            any_ne = any_ne || (m_q[k][w].size() > 0);
        end
        if (k == 1 && el[m_last[k]]) win = m_last[k];
        else
            for (int i = 0; i < NW; i++)
                if (win < 0 && el[(m_rr[k] + i) % NW]) win = (m_rr[k] + i) % NW;
        if (can_load && any_ne && win < 0 && m_stall[k] < 64'hFFFF_FFFF) m_stall[k]++;
        if (wb_valid && wb_eop) m_sb[k][wb_wid][wb_rd] = 1'b0;
        if (can_load && win >= 0) begin
            m_out[k] = m_q[k][win].pop_front();
            m_wid[k] = win;
            m_val[k] = 1'b1;
            if (m_out[k].wb && m_out[k].rd != 6'd0) m_sb[k][win][m_out[k].rd] = 1'b1;
            m_rr[k]   = (win + 1) % NW;
            m_last[k] = win;
        end else if (can_load) begin
            m_val[k] = 1'b0;
        end
        if (accept)
            m_q[k][dec_wid].push_back('{wb: dec_wb, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                                        rs3: dec_rs3, pl: dec_payload});
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("i%0d_valid", k), iss_valid_o[k], m_val[k]);
                if (m_val[k]) begin
                    chk($sformatf("i%0d_wid", k), iss_wid_o[k], m_wid[k]);
                    chk($sformatf("i%0d_wb", k), iss_wb_o[k], m_out[k].wb);
                    chk($sformatf("i%0d_rd", k), iss_rd_o[k], m_out[k].rd);
                    chk($sformatf("i%0d_rs1", k), iss_rs1_o[k], m_out[k].rs1);
                    chk($sformatf("i%0d_rs2", k), iss_rs2_o[k], m_out[k].rs2);
                    chk($sformatf("i%0d_rs3", k), iss_rs3_o[k], m_out[k].rs3);
                    chk($sformatf("i%0d_payload", k), iss_pl_o[k], m_out[k].pl);
                end
                chk($sformatf("i%0d_dec_ready", k), dec_ready_o[k], m_q[k][dec_wid].size() < DEPTH);
                chk($sformatf("i%0d_stalls", k), stalls_o[k], m_stall[k]);
                if (iss_valid_o[k] && iss_ready) begin
                    rec_pl[k].push_back(iss_pl_o[k]);
                    rec_wid[k].push_back(int'(iss_wid_o[k]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_wid = 0; dec_wb = 0; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
        dec_rs3 = 0; dec_payload = 0; wb_valid = 0; wb_wid = 0; wb_rd = 0; wb_eop = 0;
    endtask

    task automatic dec(input int w, input bit wb, input int rd, input int rs1,
                       input int rs2, input int rs3, input logic [63:0] pl);
        dec_valid = 1; dec_wid = 2'(w); dec_wb = wb; dec_rd = 6'(rd);
        dec_rs1 = 6'(rs1); dec_rs2 = 6'(rs2); dec_rs3 = 6'(rs3); dec_payload = pl;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        tick();
        reset = 0;
        for (int k = 0; k < 2; k++) begin
            rec_pl[k].delete();
            rec_wid[k].delete();
        end
    endtask

    initial begin
        logic [63:0] exp3 [4];
        int          exp_rr [8];
        int          exp_gr [8];
        exp3   = '{64'h30, 64'h11, 64'h12, 64'h13};
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_gr = '{0, 0, 1, 1, 2, 2, 3, 3};
        iss_ready = 1;
        do_reset();
        cmp_en = 1;

        // Reset state and minimum latency
        @(negedge clk);
        chk("rst_valid", iss_valid_o[0], 0);
        chk("rst_stalls", stalls_o[0], 0);
        chk("rst_ready", dec_ready_o[0], 1);
        chk("rst_rd", iss_rd_o[0], 0);
        chk("rst_payload", iss_pl_o[0], 0);
        tick();
        dec(2, 1, 5, 3, 0, 0, 64'hCAFE);
        tick(); idle();
        @(negedge clk); chk("t1_lat_t1", iss_valid_o[0], 0);
        tick();
        dec(2, 0, 0, 0, 5, 0, 64'h1);
        @(negedge clk);
        chk("t1_valid", iss_valid_o[0], 1);
        chk("t1_wid", iss_wid_o[0], 2);
        chk("t1_rd", iss_rd_o[0], 5);
        chk("t1_rs1", iss_rs1_o[0], 3);
        chk("t1_payload", iss_pl_o[0], 64'hCAFE);
        tick(); idle();
        tick();
        @(negedge clk);
        chk("t1_sb_stall", iss_valid_o[0], 0);
        chk("t1_sb_stalls", stalls_o[0], 1);

        // RAW hazard resolved by writeback
        tick(); do_reset();
        dec(0, 1, 7, 0, 0, 0, 64'hA0);
        tick(); dec(0, 0, 0, 7, 0, 0, 64'hB0);
        tick(); idle();
        @(negedge clk);
        chk("t2_first", iss_pl_o[0], 64'hA0);
        tick(); tick();
        wb_valid = 1; wb_wid = 0; wb_rd = 7; wb_eop = 1;
        @(negedge clk);
        chk("t2_stall_v", iss_valid_o[0], 0);
        chk("t2_stalls2", stalls_o[0], 2);
        tick(); idle();
        @(negedge clk);
        chk("t2_no_bypass", iss_valid_o[0], 0);
        tick();
        @(negedge clk);
        chk("t2_issue_v", iss_valid_o[0], 1);
        chk("t2_issue_pl", iss_pl_o[0], 64'hB0);
        chk("t2_stalls3", stalls_o[0], 3);

        // Buffer full back-pressure and order preservation
        tick(); do_reset();
        iss_ready = 0;
        dec(3, 0, 0, 0, 0, 0, 64'h30);
        tick(); dec(1, 0, 0, 0, 0, 0, 64'h11);
        tick(); dec(1, 0, 0, 0, 0, 0, 64'h12);
        tick(); dec(1, 0, 0, 0, 0, 0, 64'h13);
        @(negedge clk); chk("t3_full", dec_ready_o[0], 0);
        tick(); iss_ready = 1;
        @(negedge clk); chk("t3_full_hold", dec_ready_o[0], 0);
        tick();
        @(negedge clk); chk("t3_free", dec_ready_o[0], 1);
        tick(); idle();
        repeat (4) tick();
        chk("t3_count", rec_pl[0].size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rec_pl[0].size()) chk($sformatf("t3_order%0d", i), rec_pl[0][i], exp3[i]);

        // Round-robin versus greedy ordering
        do_reset();
        iss_ready = 0;
        for (int i = 0; i < 8; i++) begin
            dec(i % 4, 0, 0, 0, 0, 0, 64'h40 + 64'(i));
            tick();
        end
        idle(); iss_ready = 1;
        repeat (10) tick();
        chk("t4_rr_count", rec_wid[0].size(), 8);
        chk("t4_gr_count", rec_wid[1].size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rec_wid[0].size()) chk($sformatf("t4_rr%0d", i), rec_wid[0][i], exp_rr[i]);
            if (i < rec_wid[1].size()) chk($sformatf("t4_gr%0d", i), rec_wid[1][i], exp_gr[i]);
        end

        // rd=0 never busy; partial writeback keeps the bit
        do_reset();
        dec(1, 1, 0, 0, 0, 0, 64'h50);
        tick(); dec(1, 0, 0, 0, 0, 0, 64'h51);
        tick(); dec(2, 1, 12, 0, 0, 0, 64'h52);
        @(negedge clk); chk("t5_x", iss_pl_o[0], 64'h50);
        tick(); dec(2, 0, 0, 12, 0, 0, 64'h53);
        @(negedge clk);
        chk("t5_r0_issue", iss_pl_o[0], 64'h51);
        chk("t5_r0_nostall", stalls_o[0], 0);
        tick(); idle();
        tick(); wb_valid = 1; wb_wid = 2; wb_rd = 12; wb_eop = 0;
        tick(); idle();
        tick();
        @(negedge clk);
        chk("t5_eop0_hold", iss_valid_o[0], 0);
        chk("t5_eop0_stalls", stalls_o[0], 3);

        // Reset with a loaded output and buffered entries
        iss_ready = 0;
        dec(3, 0, 0, 0, 0, 0, 64'h60);
        tick(); dec(3, 0, 0, 0, 0, 0, 64'h61);
        tick(); dec(3, 0, 0, 0, 0, 0, 64'h62);
        tick(); dec(0, 0, 0, 0, 0, 0, 64'h63);
        tick(); idle();
        @(negedge clk);
        chk("t6_pre_valid", iss_valid_o[0], 1);
        chk("t6_pre_stalls", stalls_o[0], 4);
        reset = 1;
        tick(); reset = 0;
        @(negedge clk);
        chk("t6_valid", iss_valid_o[0], 0);
        chk("t6_stalls", stalls_o[0], 0);
        for (int w = 0; w < 4; w++) begin
            dec_wid = 2'(w);
            #1;
            chk($sformatf("t6_ready_w%0d", w), dec_ready_o[0], 1);
        end
        iss_ready = 1;
        tick(); tick();
        @(negedge clk);
        chk("t6_empty", iss_valid_o[0], 0);

        // Random traffic against the model
        tick();
        for (int c = 0; c < 300; c++) begin
            idle();
            iss_ready = ($urandom_range(9) < 7);
            if ($urandom_range(1) == 1)
                dec($urandom_range(3), 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3),
                    $urandom_range(3), $urandom_range(3), {$urandom, $urandom});
            if ($urandom_range(9) < 3) begin
                wb_valid = 1; wb_wid = 2'($urandom_range(3));
                wb_rd = 6'($urandom_range(3)); wb_eop = ($urandom_range(9) < 7);
            end
            tick();
        end
        idle();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_warp_sched.md
Name: issue_warp_sched

Overview:
- Parametrised successor to the issue-slice front end: per-warp instruction buffers, a register scoreboard and a warp arbiter in one sequential block.
- Accepts decoded instructions, holds them per warp, and releases one hazard-free instruction per cycle through a registered output stage toward operand fetch/dispatch.
- Generalised in warp count, buffer depth and register count, with a selectable arbitration mode (round-robin or greedy) and a built-in hazard-stall counter, which the fixed slice lacks.

Parameters:
- NUM_WARPS, 4, warps per slice (power of 2, >=2); NW_W = log2(NUM_WARPS).
- IBUF_DEPTH, 2, entries per warp buffer (power of 2, >=2).
- NUM_REGS, 64, architectural registers per warp; NR_W = log2(NUM_REGS).
- PAYLOAD_W, 64, opaque instruction payload bits (uuid, PC, op, tmask...).
- ARB_MODE, 0, 0 = round-robin, 1 = greedy (stay on last issued warp while it is eligible, else round-robin).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  buffer of dec_wid not full
- dec_wid  in  NW_W  warp id
- dec_wb  in  1  instruction writes rd
- dec_rd  in  NR_W  destination register
- dec_rs1, dec_rs2, dec_rs3  in  NR_W each  source registers
- dec_payload  in  PAYLOAD_W  opaque data
- wb_valid  in  1  writeback valid (no ready; always accepted)
- wb_wid  in  NW_W  writeback warp
- wb_rd  in  NR_W  writeback register
- wb_eop  in  1  last writeback packet of instruction
- iss_valid  out  1  issued instruction valid
- iss_ready  in  1  downstream accept
- iss_wid  out  NW_W  issued warp
- iss_wb  out  1  writes rd
- iss_rd  out  NR_W  destination
- iss_rs1, iss_rs2, iss_rs3  out  NR_W each  sources
- iss_payload  out  PAYLOAD_W  payload
- perf_stalls  out  32  hazard-stall cycle counter

Behaviour:
- Reset: all buffers empty, scoreboard cleared, RR pointer = 0, greedy-last = 0, iss_valid = 0, all iss_* data = 0, perf_stalls = 0. dec_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation drops all buffered and in-flight state; writebacks during reset are ignored.
- dec_ready is combinational from the fullness of buffer[dec_wid] only; no dependence on dec_valid.
- Enqueue on dec_valid && dec_ready. Each buffer is a circular FIFO with wrapping read/write pointers and a count of 0..IBUF_DEPTH.
- Simultaneous enqueue and dequeue on a full buffer is not allowed: ready stays low when full.
- Eligibility: warp w is eligible when its buffer is non-empty and the head's rs1/rs2/rs3 and rd (if wb) have clear scoreboard bits. Register 0 is never busy.
- Arbitration runs when the output stage can load (!iss_valid || iss_ready).
  - Round-robin: pick the first eligible warp starting at RR pointer, then set the pointer to winner+1 mod NUM_WARPS.
  - Greedy: keep the last warp if it is eligible, otherwise use round-robin.
- On selection: the head is dequeued into the output register and iss_valid = 1 next cycle. If wb && rd != 0, set scoreboard[w][rd] at the same edge.
- Minimum latency: decode fire at cycle T gives iss_valid at T+2 (buffer write at T, select at T+1).
- Back-to-back issue is possible from the same or different warps at one per cycle.
- Output holds stable while iss_valid && !iss_ready.
- Writeback: wb_valid && wb_eop clears scoreboard[wb_wid][wb_rd] at the edge.
  - No same-cycle bypass: the dependent instruction becomes eligible the cycle after the clear.
  - If a set and a clear hit the same bit in one cycle, the set wins.
- perf_stalls increments (saturating at 2^32-1) each cycle where the output can load, at least one buffer is non-empty, and no warp is eligible.

Decomposition:
- Shared package entry: issue_sched_ent_t struct {wb, rd, rs1, rs2, rs3, payload}, ARB_RR/ARB_GREEDY constants, and a NW_W/NR_W width helper.
- One natural sub-module: issue_warp_fifo (single-warp circular buffer, depth-parametrised), instantiated NUM_WARPS times.
- The arbiter and scoreboard stay inline.

Test Plan:
- Reset, then a single instruction for warp 2 (rd=5, rs1=3) decoded at cycle T, iss_ready=1 -> iss_valid at T+2 with wid=2, rd=5, payload echoed, and scoreboard[2][5] set.
- Warp 0 issues rd=7, then warp 0 sends rs1=7 -> second instruction stalls and perf_stalls counts each cycle. A writeback (wid=0, rd=7, eop=1) at cycle W -> issue at W+2.
- IBUF_DEPTH=2: three decodes to warp 1 with iss_ready=0 -> third sees dec_ready=0. Raise iss_ready -> dec_ready=1 next cycle, and order is preserved.
- ARB_MODE=0, all 4 warps loaded with independent instructions -> issue order 0,1,2,3,0,... one per cycle. ARB_MODE=1 -> all of warp 0 first, then warp 1.
- rd=0 with wb=1 -> no scoreboard bit is set, and a following rs1=0 instruction issues without stall. A wb_eop=0 writeback does not clear the bit.
- Assert reset while iss_valid=1 with 3 buffered entries -> iss_valid=0, perf_stalls=0, and all buffers empty next cycle.
